// File: rtl/adder_sequencer.sv
// adder_sequencer: drives an external 16-bit adder with registered operands,
// waits SETTLE_CYCLES for its result to settle, captures it and offers it on
// a valid/ready result port.
// Optional macro ADDER_SEQ_PIPE_EN: lets a new operand set be accepted in the
// same cycle the held result is drained, which removes the idle bubble.
//
// state  | meaning
// IDLE   | waiting for an operand request, in_ready high
// SETTLE | operands on the adder, counting down the settle time
// HOLD   | result captured, out_valid high until out_ready

module adder_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_overflow,
    output logic        busy,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       accept;

    // Request readiness: idle always; in HOLD only when the result drains this cycle
`ifdef ADDER_SEQ_PIPE_EN
    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);

    // Sequencer: operand capture, settle countdown, result capture and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= 4'd0;
            add_a        <= 16'd0;
            add_b        <= 16'd0;
            add_cin      <= 1'b0;
            out_sum      <= 16'd0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            op_count     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a      <= in_a;
                        add_b      <= in_b;
                        add_cin    <= in_cin;
                        settle_cnt <= CNT_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        out_sum      <= add_sum;
                        out_overflow <= add_overflow;
                        out_valid    <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        op_count  <= op_count + 8'd1;
                        out_valid <= 1'b0;
                        // accept can only be true here when pipelining is enabled
                        if (accept) begin
                            add_a      <= in_a;
                            add_b      <= in_b;
                            add_cin    <= in_cin;
                            settle_cnt <= CNT_LOAD;
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
module tb_adder_sequencer;

    localparam int S = 2;
`ifdef ADDER_SEQ_PIPE_EN
    localparam bit PIPE = 1'b1;
    localparam int PERIOD = 3;
`else
    localparam bit PIPE = 1'b0;
    localparam int PERIOD = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, in_cin = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic        in_ready, add_cin, add_overflow, out_valid, out_overflow, busy;
    logic [15:0] add_a, add_b, add_sum, out_sum;
    logic [7:0]  op_count;

    logic        in_valid_1 = 1'b0, out_ready_1 = 1'b0, in_cin_1 = 1'b0;
    logic [15:0] in_a_1 = '0, in_b_1 = '0;
    logic        in_ready_1, add_cin_1, add_overflow_1, out_valid_1, out_overflow_1, busy_1;
    logic [15:0] add_a_1, add_b_1, add_sum_1, out_sum_1;
    logic [7:0]  op_count_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // external adders: overflow is the carry out of bit 15
    assign {add_overflow, add_sum}     = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    assign {add_overflow_1, add_sum_1} = 17'(add_a_1) + 17'(add_b_1) + 17'(add_cin_1);

    adder_sequencer #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_overflow(out_overflow),
        .busy(busy), .op_count(op_count)
    );

    adder_sequencer #(.SETTLE_CYCLES(1)) u_dut_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_a(in_a_1), .in_b(in_b_1), .in_cin(in_cin_1),
        .add_a(add_a_1), .add_b(add_b_1), .add_cin(add_cin_1),
        .add_sum(add_sum_1), .add_overflow(add_overflow_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_sum(out_sum_1), .out_overflow(out_overflow_1),
        .busy(busy_1), .op_count(op_count_1)
    );

    // transaction-level model of u_dut: one pending operation with a due time
    int          edge_n  = 0;
    bit          m_pend  = 1'b0;
    int          m_due   = 0;
    logic [15:0] m_a     = '0, m_b = '0;
    logic        m_cin   = 1'b0;
    logic [16:0] m_res   = '0;
    int          m_ops   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit m_valid();
        return m_pend && (edge_n >= m_due);
    endfunction

    // one clock: update the model from the inputs seen at the edge, then compare at the falling edge
    task automatic step();
        bit hold, rdy, done, acc;
        @(posedge clk);
        hold = m_valid();
        rdy  = !m_pend || (hold && PIPE && out_ready);
        edge_n++;
        if (rst) begin
            m_pend = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_ops = 0;
        end else begin
            done = hold && out_ready;
            acc  = in_valid && rdy;
            if (done) begin
                m_ops  = (m_ops + 1) % 256;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pend = 1'b1;
                m_due  = edge_n + S;
                m_a = in_a; m_b = in_b; m_cin = in_cin;
                m_res = 17'(in_a) + 17'(in_b) + 17'(in_cin);
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid()));
        if (m_valid()) begin
            chk("out_sum", 32'(out_sum), 32'(m_res[15:0]));
            chk("out_overflow", 32'(out_overflow), 32'(m_res[16]));
        end
        chk("in_ready", 32'(in_ready), 32'(!m_pend || (m_valid() && PIPE && out_ready)));
        chk("busy", 32'(busy), 32'(m_pend));
        chk("op_count", 32'(op_count), 32'(m_ops));
        chk("add_a", 32'(add_a), 32'(m_a));
        chk("add_b", 32'(add_b), 32'(m_b));
        chk("add_cin", 32'(add_cin), 32'(m_cin));
    endtask

    int done_cnt;
    int vtimes[$];

    initial begin
        // reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);

        // 0xFFFF + 0x0002: two-cycle latency, carry out
        in_a = 16'hFFFF; in_b = 16'h0002; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready_settle", 32'(in_ready), 32'd0);
        step();
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'h0001);
        chk("t1_ovf", 32'(out_overflow), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 0xFFFF + 0xFFFF + 1 held under backpressure, new requests ignored
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
        step();
        in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 32'(out_valid), 32'd1);
            chk("t2_sum", 32'(out_sum), 32'hFFFF);
            chk("t2_ovf", 32'(out_overflow), 32'd1);
            chk("t2_in_ready", 32'(in_ready), 32'd0);
            chk("t2_add_a", 32'(add_a), 32'hFFFF);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_op_count", 32'(op_count), 32'd2);

        // reset one cycle after accept discards the operation
        in_a = 16'h0002; in_b = 16'h0002; in_cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t3_add_a", 32'(add_a), 32'h0000);
        chk("t3_op_count", 32'(op_count), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_no_valid", 32'(out_valid), 32'd0);
        end

        // streaming throughput
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_a = 16'(i * 16'h0111); in_b = 16'(16'hF000 + i); in_cin = i[0];
            step();
            if (out_valid) vtimes.push_back(edge_n);
        end
        in_valid = 1'b0;
        chk("t4_results_seen", 32'(vtimes.size() >= 4), 32'd1);
        for (int i = 1; i < vtimes.size(); i++)
            chk("t4_period", 32'(vtimes[i] - vtimes[i-1]), 32'(PERIOD));
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b0;

        // 256 zero additions wrap op_count
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 2000 && done_cnt < 256; i++) begin
            step();
            if (out_valid) begin
                chk("t5_sum", 32'(out_sum), 32'h0000);
                chk("t5_ovf", 32'(out_overflow), 32'd0);
                done_cnt++;
                if (done_cnt == 256) in_valid = 1'b0;
            end
        end
        chk("t5_completions", 32'(done_cnt), 32'd256);
        step();
        chk("t5_op_count_wrap", 32'(op_count), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        out_ready = 1'b0;

        // SETTLE_CYCLES=1 instance: 0x8000 + 0x8000
        chk("t6_rst_ready", 32'(in_ready_1), 32'd1);
        in_a_1 = 16'h8000; in_b_1 = 16'h8000; in_cin_1 = 1'b0; in_valid_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        chk("t6_settle", 32'(out_valid_1), 32'd0);
        chk("t6_busy", 32'(busy_1), 32'd1);
        step();
        chk("t6_valid", 32'(out_valid_1), 32'd1);
        chk("t6_sum", 32'(out_sum_1), 32'h0000);
        chk("t6_ovf", 32'(out_overflow_1), 32'd1);
        out_ready_1 = 1'b1;
        step();
        out_ready_1 = 1'b0;
        chk("t6_op_count", 32'(op_count_1), 32'd1);
        chk("t6_drained", 32'(out_valid_1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, which sets the cycles operands are held on the adder before capture; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: one clock, reset synchronous and active-high.
REQ-004 The block SHALL have ports in_valid, input, 1, and in_ready, output, 1: the operand request handshake.
REQ-005 The block SHALL have ports in_a and in_b, input, 16 each, and in_cin, input, 1: the requested operands and carry-in.
REQ-006 The block SHALL have ports add_a and add_b, output, 16 each, and add_cin, output, 1: registered drives to the 16-bit adder a/b/carry_in.
REQ-007 The block SHALL have ports add_sum, input, 16, and add_overflow, input, 1: the 16-bit adder's sum and overflow results.
REQ-008 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1: the result handshake.
REQ-009 The block SHALL have ports out_sum, output, 16, and out_overflow, output, 1: the captured result.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port op_count, output, 8: the number of completed results.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, SETTLE and HOLD.
REQ-013 In IDLE, in_ready SHALL be 1; in SETTLE in_ready SHALL be 0; in HOLD in_ready SHALL be per REQ-024/025.
REQ-014 On accept (in_valid and in_ready at an edge), the block SHALL:
- register in_a, in_b and in_cin into add_a, add_b and add_cin;
- load the settle counter with SETTLE_CYCLES-1;
- move to SETTLE.
REQ-015 add_a, add_b and add_cin SHALL change only on accept, otherwise holding their value.
REQ-016 In SETTLE, each edge SHALL decrement the counter when it is nonzero; at the edge where the counter is 0 the block SHALL capture add_sum and add_overflow into out_sum and out_overflow and move to HOLD.
REQ-017 Latency SHALL be exactly SETTLE_CYCLES cycles: accept at edge k leads to out_valid=1 after edge k+SETTLE_CYCLES.
REQ-018 out_valid SHALL be 1 only in HOLD.
REQ-019 out_sum and out_overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 In HOLD, out_valid and out_ready at an edge SHALL complete the transfer: op_count increments, and the state follows REQ-024/025.
REQ-021 op_count SHALL wrap from 255 to 0.
REQ-022 out_ready asserted outside HOLD SHALL be ignored.
REQ-023 in_valid asserted while in_ready=0 SHALL be ignored, with no capture and no state change.

Configuration
REQ-024 With ADDER_SEQ_PIPE_EN defined:
- in HOLD, in_ready SHALL equal out_ready;
- simultaneous completion and accept at one edge SHALL register the new operands, reload the counter and enter SETTLE directly;
- completion without accept SHALL go to IDLE.
REQ-025 Without ADDER_SEQ_PIPE_EN, in HOLD in_ready SHALL be 0, and completion SHALL always go to IDLE (one-cycle bubble between results).

Reset
REQ-026 While rst=1 at an edge, the block SHALL go to IDLE and clear to 0: add_a, add_b, add_cin, out_sum, out_overflow, out_valid, busy, op_count and the settle counter; in_ready SHALL be 1 after reset.
REQ-027 Reset asserted in SETTLE or HOLD SHALL discard the operation in flight, with no out_valid pulse and no op_count change.
REQ-028 Reset SHALL take priority over simultaneous accept or completion.

Verification
REQ-029 The bench SHALL cover: SETTLE_CYCLES=2, accept in_a=0xFFFF, in_b=0x0002, in_cin=0 -> after 2 cycles out_valid=1, out_sum=0x0001, out_overflow=1, op_count 0->1 on drain.
REQ-030 The bench SHALL cover: in_a=0xFFFF, in_b=0xFFFF, in_cin=1 with out_ready=0 for 5 cycles -> out_valid held, out_sum=0xFFFF, out_overflow=1 stable, in_ready=0, new in_valid ignored.
REQ-031 The bench SHALL cover: in_a=0x0002, in_b=0x0002, in_cin=0, with rst pulsed one cycle after accept -> IDLE, out_valid never 1, add_a=0x0000, op_count=0.
REQ-032 The bench SHALL cover: with ADDER_SEQ_PIPE_EN, out_ready=1 and in_valid=1 held continuously -> one result every SETTLE_CYCLES+1 cycles; without the macro -> one result every SETTLE_CYCLES+2 cycles.
REQ-033 The bench SHALL cover: 256 completed operations of 0x0000+0x0000+0 -> op_count reads 0, all out_sum=0x0000, out_overflow=0.
REQ-034 The bench SHALL cover: SETTLE_CYCLES=1, accept 0x8000+0x8000+0 -> out_valid after exactly 1 cycle, out_sum=0x0000, out_overflow=1.
